// File: rtl/spi_flash_dev.sv
// spi_flash_dev: SPI mode-0 serial flash read-only device model (03h/0Bh/9Fh/05h)
// fronting a 32-bit word memory; sck/ss/mosi are oversampled on the system clock.
module spi_flash_dev #(
    parameter int          ADDR_BYTES   = 3,
    parameter int          DUMMY_CYCLES = 8,
    parameter logic [23:0] JEDEC_ID     = 24'hEF4018,
    parameter int          MEM_AW       = 22
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              sck,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic              mem_ren,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              err
);
    localparam int         BA         = MEM_AW + 2;
    localparam logic [5:0] ADDR_LAST  = 6'(8 * ADDR_BYTES - 1);
    localparam logic [5:0] DUMMY_LAST = 6'(DUMMY_CYCLES - 1);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, ID, STAT, ERR} state_t;
    state_t      state;
    logic [1:0]  sck_s, ss_s, mosi_s;
    logic        sck_d, armed, fast, pend;
    logic [5:0]  cnt;
    logic [2:0]  tx_bit;
    logic [1:0]  id_idx;
    logic [6:0]  cmd, shreg;
    logic [BA-2:0] addr_sr;
    logic [BA-1:0] byte_addr;
    logic [31:0] cur_word;
    logic        rise, fall, m;
    logic [7:0]  cmd_nx, id_byte, tx_byte;
    logic [BA-1:0] addr_nx;
    assign rise    = sck_s[1] & ~sck_d;
    assign fall    = ~sck_s[1] & sck_d;
    assign m       = mosi_s[1];
    assign cmd_nx  = {cmd, m};
    assign addr_nx = {addr_sr, m};
    assign id_byte = id_idx == 2'd0 ? JEDEC_ID[23:16] :
                     id_idx == 2'd1 ? JEDEC_ID[15:8]  :
                     id_idx == 2'd2 ? JEDEC_ID[7:0]   : 8'h00;
    assign tx_byte = state == DATA ? cur_word[{byte_addr[1:0], 3'b000} +: 8] :
                     state == ID   ? id_byte : 8'h00;
    // armed is only set by a synchronised ss high, so a block released from reset
    // with ss already low waits for a fresh select before listening to sck.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sck_s     <= '0;
            ss_s      <= '0;
            mosi_s    <= '0;
            sck_d     <= 1'b0;
            state     <= IDLE;
            armed     <= 1'b0;
            fast      <= 1'b0;
            pend      <= 1'b0;
            cnt       <= '0;
            tx_bit    <= '0;
            id_idx    <= '0;
            cmd       <= '0;
            shreg     <= '0;
            addr_sr   <= '0;
            byte_addr <= '0;
            cur_word  <= '0;
            miso      <= 1'b1;
            mem_ren   <= 1'b0;
            mem_addr  <= '0;
            err       <= 1'b0;
        end else begin
            sck_s   <= {sck_s[0], sck};
            ss_s    <= {ss_s[0], ss};
            mosi_s  <= {mosi_s[0], mosi};
            sck_d   <= sck_s[1];
            mem_ren <= 1'b0;
            pend    <= mem_ren;
            if (pend)
                cur_word <= mem_rdata;
            if (ss_s[1]) begin
                state  <= IDLE;
                armed  <= 1'b1;
                pend   <= 1'b0;
                cnt    <= '0;
                tx_bit <= '0;
                id_idx <= '0;
                miso   <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (armed) begin
                        state   <= CMD;
                        armed   <= 1'b0;
                        cmd     <= '0;
                        addr_sr <= '0;
                        shreg   <= '0;
                    end
                    CMD: if (rise) begin
                        cmd <= cmd_nx[6:0];
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd7) begin
                            cnt  <= '0;
                            fast <= cmd_nx == 8'h0B;
                            case (cmd_nx)
                                8'h03, 8'h0B: state <= ADDR;
                                8'h9F:        state <= ID;
                                8'h05:        state <= STAT;
                                default: begin
                                    state <= ERR;
                                    err   <= 1'b1;
                                end
                            endcase
                        end
                    end
                    ADDR: if (rise) begin
                        addr_sr <= addr_nx[BA-2:0];
                        cnt     <= cnt + 6'd1;
                        if (cnt == ADDR_LAST) begin
                            cnt       <= '0;
                            byte_addr <= addr_nx;
                            if (fast && DUMMY_CYCLES > 0)
                                state <= DUMMY;
                            else begin
                                state    <= DATA;
                                mem_ren  <= 1'b1;
                                mem_addr <= addr_nx[BA-1:2];
                            end
                        end
                    end
                    DUMMY: if (rise) begin
                        cnt <= cnt + 6'd1;
                        if (cnt == DUMMY_LAST) begin
                            cnt      <= '0;
                            state    <= DATA;
                            mem_ren  <= 1'b1;
                            mem_addr <= byte_addr[BA-1:2];
                        end
                    end
                    DATA, ID, STAT: if (fall) begin
                        tx_bit <= tx_bit + 3'd1;
                        miso   <= tx_bit == 3'd0 ? tx_byte[7] : shreg[6];
                        shreg  <= tx_bit == 3'd0 ? tx_byte[6:0] : {shreg[5:0], 1'b0};
                        // the last byte of a word is already in shreg, so its word
                        // register can take the next fetch without a gap
                        if (tx_bit == 3'd0 && state == DATA) begin
                            byte_addr <= byte_addr + BA'(1);
                            if (byte_addr[1:0] == 2'd3) begin
                                mem_ren  <= 1'b1;
                                mem_addr <= byte_addr[BA-1:2] + MEM_AW'(1);
                            end
                        end
                        if (tx_bit == 3'd0 && state == ID && id_idx != 2'd3)
                            id_idx <= id_idx + 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/spi_flash_dev.md
SPI_FLASH_DEV -- requirements
Module: spi_flash_dev

Interface
REQ-001 The parameter ADDR_BYTES, default 3, SHALL set the address length in bytes; legal values are 3 and 4.
REQ-002 The parameter DUMMY_CYCLES, default 8, SHALL set the number of sck cycles between the address and the data of a 0Bh command; legal range is 0..15.
REQ-003 The parameter JEDEC_ID, default 24'hEF4018, SHALL set the three bytes returned by 9Fh, most significant byte first.
REQ-004 The parameter MEM_AW, default 22, SHALL set the word-address width of the backing memory port.
REQ-005 clock  in  1  system clock; all state SHALL be on its rising edge; its frequency SHALL be at least 8x the sck frequency.
REQ-006 resetn  in  1  reset, asynchronous, active-low.
REQ-007 sck  in  1  SPI serial clock, mode 0, asynchronous to clock.
REQ-008 ss  in  1  chip select, active-low.
REQ-009 mosi  in  1  serial data from the host, sampled on sck rise.
REQ-010 miso  out  1  serial data to the host, changed only after sck fall or on ss change.
REQ-011 mem_ren  out  1  one-cycle read strobe to the backing memory.
REQ-012 mem_addr  out  MEM_AW  word address of the read.
REQ-013 mem_rdata  in  32  read data, valid on the clock cycle after mem_ren; little-endian (byte 0 = bits 7:0).
REQ-014 err  out  1  sticky flag for an unsupported command.

Function
REQ-015 sck, ss and mosi SHALL each pass through a 2-flop synchroniser; sck rise and fall SHALL be detected from the synchronised sck.
REQ-016 Synchronised ss high SHALL force state IDLE, clear all bit counters, cancel any pending fetch, and drive miso=1 within 3 clocks.
REQ-017 The FSM states SHALL be IDLE, CMD, ADDR, DUMMY, DATA, ID, STAT and ERR.
REQ-018 Transitions: IDLE->CMD on ss low; CMD->(per command) after 8 rising edges.
REQ-019 Per-command targets: 03h->ADDR; 0Bh->ADDR; 9Fh->ID; 05h->STAT; any other value->ERR.
REQ-020 From ADDR: after 8*ADDR_BYTES rising edges, go to DUMMY for 0Bh when DUMMY_CYCLES>0, otherwise to DATA; DUMMY->DATA after DUMMY_CYCLES rising edges.
REQ-021 Command, address and data bits SHALL be MSB first.
REQ-022 For a 4-byte address, only bits [MEM_AW+1:0] SHALL be used.
REQ-023 Entry into DATA SHALL issue mem_ren with mem_addr = byte_addr[MEM_AW+1:2].
REQ-024 The first bit of the byte at byte_addr, including byte_addr[1:0]!=0, SHALL be on miso before the next sck rise.
REQ-025 Bytes SHALL stream with the byte address incrementing by 1; word address wrap-around from 2^MEM_AW-1 to 0 is required.
REQ-026 On the sck fall that starts the last byte of a word, the next word SHALL be fetched (mem_ren) so that no gap appears at the word boundary.
REQ-027 ID SHALL shift out JEDEC_ID bytes 2,1,0, then 8'h00 until ss rises.
REQ-028 STAT SHALL shift out 8'h00 repeatedly; the device is never busy.
REQ-029 ERR SHALL set err=1 and hold miso=1, with no mem_ren, until ss rises; err SHALL be cleared only by resetn.
REQ-030 ss rising mid-byte or mid-address SHALL abort the transaction silently, with no err and no further mem_ren.
REQ-031 At most one mem_ren SHALL be outstanding at any time; mem_ren SHALL never be asserted outside DATA.

Reset
REQ-032 While resetn=0: state=IDLE, miso=1, mem_ren=0, mem_addr=0, err=0, all counters and shift registers 0.
REQ-033 resetn deassertion while ss=0 SHALL leave the block in IDLE; the block SHALL ignore sck until ss has been high and then low again.

Verification
REQ-034 Memory word 0 = 32'h44332211; ss low; send 03h, addr 000000h; clock 32 data bits -> miso bytes 11h 22h 33h 44h, mem_ren pulses exactly twice (words 0 and 1).
REQ-035 Send 0Bh, addr 000002h, 8 dummy cycles; word 0 = 32'h44332211, word 1 = 32'h88776655 -> miso bytes 33h 44h 55h 66h, with no gap at the boundary.
REQ-036 Send 9Fh, read 4 bytes -> EFh 40h 18h 00h; err=0.
REQ-037 Send 02h -> err=1 after the 8th bit, miso=1 and no mem_ren until ss rises; next 03h transaction reads correctly while err stays 1.
REQ-038 Send 03h with ss raised after 12 address bits, then a full 03h read of addr 000004h -> only the second transaction fetches, returning word-1 bytes.
REQ-039 Assert resetn=0 mid-DATA -> miso=1, mem_ren=0, err=0 immediately; after release, a fresh 05h read returns 00h.
